// File: rtl/decompressor_pkg.sv
// Shared definitions for the RLE decompressor: FSM encoding and token field layout.
// A token is {run code, value}; the run length is the run code plus one.
package decompressor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WT   = 3'd2,
      ST_WR   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   localparam int TOKEN_W = 16;
   localparam int RUN_MSB = 15;
   localparam int RUN_LSB = 8;
   localparam int VAL_MSB = 7;
   localparam int VAL_LSB = 0;
   localparam int RUN_W   = RUN_MSB - RUN_LSB + 1;
   localparam int VAL_W   = VAL_MSB - VAL_LSB + 1;

   function automatic logic [RUN_W-1:0] token_run(input logic [TOKEN_W-1:0] tok);
      return tok[RUN_MSB:RUN_LSB];
   endfunction

   function automatic logic [VAL_W-1:0] token_value(input logic [TOKEN_W-1:0] tok);
      return tok[VAL_MSB:VAL_LSB];
   endfunction

endpackage

// File: rtl/rle_decompressor.sv
// Expands run-length tokens from SRAM into a frame buffer, one pixel per cycle.
// Its done output chains to the VGA controller start once a frame is complete.
module rle_decompressor
   import decompressor_pkg::*;
#(
   parameter int            AW           = 20,
   parameter int            DW           = 16,
   parameter int            IMAGE_WIDTH  = 320,
   parameter int            IMAGE_HEIGHT = 240,
   parameter logic [AW-1:0] SRC_BASE     = AW'(20'h00000),
   parameter logic [AW-1:0] DST_BASE     = AW'(20'h20000)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rdata,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic          wr_enable
);

   localparam int            TOTAL   = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int            PW      = $clog2(TOTAL) + 1;
   localparam logic [PW-1:0] TOTAL_P = PW'(TOTAL);

   state_t           r_state;
   logic [PW-1:0]    r_pix;
   logic [AW-1:0]    r_tok;
   logic [RUN_W-1:0] r_left;
   logic             r_done;
   logic             r_wr_enable;
   logic [AW-1:0]    r_raddr;
   logic [AW-1:0]    r_waddr;
   logic [DW-1:0]    r_wdata;

   logic [AW-1:0]    w_src_addr;
   logic [AW-1:0]    w_dst_addr;
   logic [RUN_W-1:0] w_run;
   logic [VAL_W-1:0] w_val;
   logic             w_frame_end;

   assign w_src_addr  = SRC_BASE + r_tok;
   assign w_dst_addr  = DST_BASE + AW'(r_pix);
   assign w_run       = token_run(rdata);
   assign w_val       = token_value(rdata);
   assign w_frame_end = (r_pix == TOTAL_P);

   // The first pixel of a run is issued while the token is captured, so the
   // WR state lasts exactly as many cycles as pixels are written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_pix       <= '0;
         r_tok       <= '0;
         r_left      <= '0;
         r_done      <= 1'b0;
         r_wr_enable <= 1'b0;
         r_raddr     <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wr_enable <= 1'b0;
               if (start) begin
                  r_pix   <= '0;
                  r_tok   <= '0;
                  r_done  <= 1'b0;
                  r_raddr <= SRC_BASE;
                  r_state <= ST_RD;
               end
            end
            ST_RD: begin
               r_state <= ST_WT;
            end
            ST_WT: begin
               r_left      <= w_run;
               r_tok       <= r_tok + 1'b1;
               r_wr_enable <= 1'b1;
               r_waddr     <= w_dst_addr;
               r_wdata     <= {{(DW-VAL_W){1'b0}}, w_val};
               r_pix       <= r_pix + 1'b1;
               r_state     <= ST_WR;
            end
            ST_WR: begin
               // Frame end wins over the remaining run, which truncates it.
               if (w_frame_end) begin
                  r_wr_enable <= 1'b0;
                  r_state     <= ST_FIN;
               end else if (r_left == '0) begin
                  r_wr_enable <= 1'b0;
                  r_raddr     <= w_src_addr;
                  r_state     <= ST_RD;
               end else begin
                  r_waddr <= w_dst_addr;
                  r_pix   <= r_pix + 1'b1;
                  r_left  <= r_left - 1'b1;
               end
            end
            ST_FIN: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_wr_enable <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign done      = r_done;
   assign raddr     = r_raddr;
   assign waddr     = r_waddr;
   assign wdata     = r_wdata;
   assign wr_enable = r_wr_enable;

endmodule
